// File: rtl/lsu_dm_master.sv
// Load/store unit driving a byte-addressed data memory: one request at a time,
// alignment/range checking, half stores split into two byte writes, load extension.
module lsu_dm_master #(
   parameter int ADDR_WIDTH = 10
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [1:0]  req_size,
   input  logic        req_unsigned,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        resp_valid,
   output logic [31:0] resp_rdata,
   output logic        resp_err,
   output logic [11:0] mem_addr,
   output logic [31:0] mem_din,
   output logic        mem_we,
   output logic        mem_sb,
   output logic        mem_lb,
   input  logic [31:0] mem_dout
);

   localparam int PAD = 12 - ADDR_WIDTH;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_W    = 3'd1,
      ST_B0   = 3'd2,
      ST_B1   = 3'd3,
      ST_LD   = 3'd4,
      ST_RESP = 3'd5
   } state_t;

   state_t                  state_r;
   state_t                  state_next_s;
   logic                    accept_s;
   logic                    err_s;
   logic [ADDR_WIDTH-1:0]   addr_r;
   logic [ADDR_WIDTH-1:0]   addr_p1_s;
   logic [31:0]             wdata_r;
   logic [1:0]              size_r;
   logic                    unsigned_r;
   logic                    ready_r;
   logic                    resp_valid_r;
   logic                    resp_err_r;
   logic [31:0]             rdata_r;

   // Sign- or zero-extend the addressed part of a memory read word
   function automatic logic [31:0] load_extend(input logic [31:0] dout,
                                               input logic [1:0]  size,
                                               input logic        uns);
      logic [31:0] res;
      case (size)
         2'b00:   res = {{24{~uns & dout[7]}}, dout[7:0]};
         2'b01:   res = {{16{~uns & dout[15]}}, dout[15:0]};
         default: res = dout;
      endcase
      return res;
   endfunction

   assign accept_s  = req_valid & (state_r == ST_IDLE);
   assign addr_p1_s = addr_r + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

   // Request legality: size, natural alignment and address range
   always_comb begin
      err_s = 1'b0;
      if (req_size == 2'b11) begin
         err_s = 1'b1;
      end else if ((req_size == 2'b01) && req_addr[0]) begin
         err_s = 1'b1;
      end else if ((req_size == 2'b10) && (req_addr[1:0] != 2'b00)) begin
         err_s = 1'b1;
      end else begin
         err_s = |req_addr[31:ADDR_WIDTH];
      end
   end

   // Next-state logic
   always_comb begin
      state_next_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (!req_valid) begin
               state_next_s = ST_IDLE;
            end else if (err_s) begin
               state_next_s = ST_RESP;
            end else if (req_we) begin
               state_next_s = (req_size == 2'b10) ? ST_W : ST_B0;
            end else begin
               state_next_s = ST_LD;
            end
         end
         ST_W:    state_next_s = ST_RESP;
         ST_B0:   state_next_s = (size_r == 2'b01) ? ST_B1 : ST_RESP;
         ST_B1:   state_next_s = ST_RESP;
         ST_LD:   state_next_s = ST_RESP;
         ST_RESP: state_next_s = ST_IDLE;
         default: state_next_s = ST_IDLE;
      endcase
   end

   // Memory control decode from the current state and latched request
   always_comb begin
      mem_we   = 1'b0;
      mem_sb   = 1'b0;
      mem_addr = {{PAD{1'b0}}, addr_r};
      mem_din  = wdata_r;
      case (state_r)
         ST_W: begin
            mem_we = 1'b1;
         end
         ST_B0: begin
            mem_we = 1'b1;
            mem_sb = 1'b1;
         end
         ST_B1: begin
            mem_we   = 1'b1;
            mem_sb   = 1'b1;
            mem_addr = {{PAD{1'b0}}, addr_p1_s};
            mem_din  = {wdata_r[31:8], wdata_r[15:8]};
         end
         default: begin
            mem_we = 1'b0;
         end
      endcase
   end

   // State, request latches and registered response outputs
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_r      <= ST_IDLE;
         ready_r      <= 1'b1;
         resp_valid_r <= 1'b0;
         resp_err_r   <= 1'b0;
         rdata_r      <= 32'h0000_0000;
         addr_r       <= {ADDR_WIDTH{1'b0}};
         wdata_r      <= 32'h0000_0000;
         size_r       <= 2'b00;
         unsigned_r   <= 1'b0;
      end else begin
         state_r      <= state_next_s;
         ready_r      <= (state_next_s == ST_IDLE);
         resp_valid_r <= (state_next_s == ST_RESP);
         // Only an erroring accept goes straight to RESP with an error flag
         resp_err_r   <= accept_s & err_s;
         if (accept_s) begin
            addr_r     <= req_addr[ADDR_WIDTH-1:0];
            wdata_r    <= req_wdata;
            size_r     <= req_size;
            unsigned_r <= req_unsigned;
         end
         if (state_r == ST_LD) begin
            rdata_r <= load_extend(mem_dout, size_r, unsigned_r);
         end
      end
   end

   assign req_ready  = ready_r;
   assign resp_valid = resp_valid_r;
   assign resp_err   = resp_err_r;
   assign resp_rdata = rdata_r;
   assign mem_lb     = 1'b0;

endmodule

// File: tb/tb_lsu_dm_master.sv
// Directed bench for lsu_dm_master: a byte-array memory model, hand-written
// corner sequences and a table of requests with hand-computed results.
module tb_lsu_dm_master;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic        req_we = 1'b0;
   logic [1:0]  req_size = 2'b00;
   logic        req_unsigned = 1'b0;
   logic [31:0] req_addr = 32'h0;
   logic [31:0] req_wdata = 32'h0;
   logic        resp_valid;
   logic [31:0] resp_rdata;
   logic        resp_err;
   logic [11:0] mem_addr;
   logic [31:0] mem_din;
   logic        mem_we;
   logic        mem_sb;
   logic        mem_lb;
   logic [31:0] mem_dout;

   int n_total = 0;
   int n_pass  = 0;

   logic [7:0] mem_m [0:4095];

   lsu_dm_master #(.ADDR_WIDTH(10)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
      .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
      .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
      .resp_err(resp_err), .mem_addr(mem_addr), .mem_din(mem_din),
      .mem_we(mem_we), .mem_sb(mem_sb), .mem_lb(mem_lb), .mem_dout(mem_dout)
   );

   always #5 clk = ~clk;

   // Little-endian byte memory, combinational read, write on rising edge
   assign mem_dout = {mem_m[12'(mem_addr + 12'd3)], mem_m[12'(mem_addr + 12'd2)],
                      mem_m[12'(mem_addr + 12'd1)], mem_m[mem_addr]};

   always @(posedge clk) begin
      if (mem_we) begin
         if (mem_sb) begin
            mem_m[mem_addr] <= mem_din[7:0];
         end else begin
            mem_m[mem_addr]                 <= mem_din[7:0];
            mem_m[12'(mem_addr + 12'd1)]    <= mem_din[15:8];
            mem_m[12'(mem_addr + 12'd2)]    <= mem_din[23:16];
            mem_m[12'(mem_addr + 12'd3)]    <= mem_din[31:24];
         end
      end
   end

   typedef struct {
      logic        we;
      logic [1:0]  size;
      logic        uns;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic        err;
      logic [31:0] rdata;
      int          lat;
   } vec_t;

   vec_t vecs[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   task automatic add(input logic we, input logic [1:0] size, input logic uns,
                      input logic [31:0] addr, input logic [31:0] wdata,
                      input logic err, input logic [31:0] rdata, input int lat);
      vec_t v;
      v.we = we; v.size = size; v.uns = uns; v.addr = addr; v.wdata = wdata;
      v.err = err; v.rdata = rdata; v.lat = lat;
      vecs.push_back(v);
   endtask

   task automatic drive(input logic we, input logic [1:0] size, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wdata);
      req_valid = 1'b1; req_we = we; req_size = size; req_unsigned = uns;
      req_addr = addr; req_wdata = wdata;
   endtask

   task automatic do_req(input vec_t v, input int idx);
      int  n;
      int  lat;
      bit  saw_we;
      @(negedge clk);
      drive(v.we, v.size, v.uns, v.addr, v.wdata);
      n = 0;
      while (!req_ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (n >= 20) chk($sformatf("v%0d_ready_timeout", idx), 32'd0, 32'd1);
      @(posedge clk);
      #1 req_valid = 1'b0;
      lat = 0;
      saw_we = 1'b0;
      do begin
         @(negedge clk);
         lat++;
         if (mem_we) saw_we = 1'b1;
      end while (!resp_valid && lat < 10);
      chk($sformatf("v%0d_latency", idx), 32'(lat), 32'(v.lat));
      chk($sformatf("v%0d_err", idx), {31'd0, resp_err}, {31'd0, v.err});
      chk($sformatf("v%0d_rdata", idx), resp_rdata, v.rdata);
      chk($sformatf("v%0d_mem_we_seen", idx), {31'd0, saw_we}, {31'd0, v.we & ~v.err});
      @(negedge clk);
      chk($sformatf("v%0d_pulse_end", idx), {31'd0, resp_valid}, 32'd0);
   endtask

   initial begin
      for (int i = 0; i < 4096; i++) mem_m[i] = 8'h00;
      mem_m[17] = 8'hAA;

      // Reset state
      repeat (2) @(negedge clk);
      chk("rst_ready", {31'd0, req_ready}, 32'd1);
      chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
      chk("rst_rdata", resp_rdata, 32'd0);
      rst = 1'b1;

      // Reset while in ST_B0 of a half store to 0x10
      @(negedge clk);
      drive(1'b1, 2'b01, 1'b0, 32'h10, 32'h0000_1234);
      @(posedge clk);
      #1 req_valid = 1'b0;
      @(negedge clk);
      chk("abort_b0_we", {30'd0, mem_we, mem_sb}, 32'd3);
      chk("abort_b0_addr", {20'd0, mem_addr}, 32'h10);
      rst = 1'b0;
      #1;
      chk("abort_outs", {29'd0, resp_valid, resp_err, mem_we}, 32'd0);
      chk("abort_sb_lb", {30'd0, mem_sb, mem_lb}, 32'd0);
      chk("abort_addr", {20'd0, mem_addr}, 32'd0);
      chk("abort_din", mem_din, 32'd0);
      chk("abort_rdata", resp_rdata, 32'd0);
      @(negedge clk);
      rst = 1'b1;
      repeat (2) @(negedge clk);
      chk("abort_ready", {31'd0, req_ready}, 32'd1);
      chk("abort_byte11", {24'd0, mem_m[17]}, 32'hAA);

      // Half store 0xBEEF to 0x42, cycle by cycle
      @(negedge clk);
      drive(1'b1, 2'b01, 1'b0, 32'h42, 32'h0000_BEEF);
      @(posedge clk);
      #1 req_valid = 1'b0;
      @(negedge clk);
      chk("sh_c1_ctl", {30'd0, mem_we, mem_sb}, 32'd3);
      chk("sh_c1_addr", {20'd0, mem_addr}, 32'h42);
      chk("sh_c1_din", {24'd0, mem_din[7:0]}, 32'hEF);
      @(negedge clk);
      chk("sh_c2_ctl", {30'd0, mem_we, mem_sb}, 32'd3);
      chk("sh_c2_addr", {20'd0, mem_addr}, 32'h43);
      chk("sh_c2_din", {24'd0, mem_din[7:0]}, 32'hBE);
      @(negedge clk);
      chk("sh_c3_resp", {29'd0, resp_valid, resp_err, mem_we}, 32'd4);

      // Request held while busy: accepted only in the IDLE cycle after RESP
      @(negedge clk);
      drive(1'b1, 2'b10, 1'b0, 32'h30, 32'hCAFE_F00D);
      @(posedge clk);
      #1 drive(1'b0, 2'b10, 1'b0, 32'h30, 32'h0);
      @(negedge clk);
      chk("hold_c1_ready", {31'd0, req_ready}, 32'd0);
      @(negedge clk);
      chk("hold_c2", {30'd0, req_ready, resp_valid}, 32'd1);
      @(negedge clk);
      chk("hold_c3_idle", {30'd0, req_ready, resp_valid}, 32'd2);
      @(posedge clk);
      #1 req_valid = 1'b0;
      @(negedge clk);
      chk("hold_c4_ld", {30'd0, req_ready, mem_we}, 32'd0);
      @(negedge clk);
      chk("hold_c5_resp", {31'd0, resp_valid}, 32'd1);
      chk("hold_c5_rdata", resp_rdata, 32'hCAFE_F00D);

      // we, size, uns, addr, wdata, err, rdata (expected, held), latency
      add(1'b1, 2'b10, 1'b0, 32'h20,  32'h1234_5678, 1'b0, 32'hCAFE_F00D, 2);
      add(1'b0, 2'b10, 1'b0, 32'h20,  32'h0,         1'b0, 32'h1234_5678, 2);
      add(1'b0, 2'b01, 1'b0, 32'h42,  32'h0,         1'b0, 32'hFFFF_BEEF, 2);
      add(1'b0, 2'b01, 1'b1, 32'h42,  32'h0,         1'b0, 32'h0000_BEEF, 2);
      add(1'b1, 2'b00, 1'b0, 32'h7,   32'h0000_0080, 1'b0, 32'h0000_BEEF, 2);
      add(1'b0, 2'b00, 1'b0, 32'h7,   32'h0,         1'b0, 32'hFFFF_FF80, 2);
      add(1'b0, 2'b00, 1'b1, 32'h7,   32'h0,         1'b0, 32'h0000_0080, 2);
      add(1'b0, 2'b10, 1'b0, 32'h22,  32'h0,         1'b1, 32'h0000_0080, 1);
      add(1'b1, 2'b01, 1'b0, 32'h23,  32'h1111,      1'b1, 32'h0000_0080, 1);
      add(1'b0, 2'b11, 1'b0, 32'h0,   32'h0,         1'b1, 32'h0000_0080, 1);
      add(1'b1, 2'b10, 1'b0, 32'h400, 32'h5555_5555, 1'b1, 32'h0000_0080, 1);
      add(1'b0, 2'b10, 1'b0, 32'h8000_0020, 32'h0,   1'b1, 32'h0000_0080, 1);
      add(1'b1, 2'b10, 1'b0, 32'h3FC, 32'hDEAD_BEEF, 1'b0, 32'h0000_0080, 2);
      add(1'b0, 2'b10, 1'b0, 32'h3FC, 32'h0,         1'b0, 32'hDEAD_BEEF, 2);
      add(1'b1, 2'b01, 1'b0, 32'h3FE, 32'hFFFF_A55A, 1'b0, 32'hDEAD_BEEF, 3);
      add(1'b0, 2'b01, 1'b1, 32'h3FE, 32'h0,         1'b0, 32'h0000_A55A, 2);
      add(1'b0, 2'b10, 1'b0, 32'h3FC, 32'h0,         1'b0, 32'hA55A_BEEF, 2);
      add(1'b0, 2'b00, 1'b0, 32'h3FF, 32'h0,         1'b0, 32'hFFFF_FFA5, 2);
      add(1'b0, 2'b10, 1'b1, 32'h20,  32'h0,         1'b0, 32'h1234_5678, 2);
      add(1'b0, 2'b00, 1'b0, 32'h21,  32'h0,         1'b0, 32'h0000_0056, 2);

      foreach (vecs[i]) do_req(vecs[i], i);

      chk("mem_byte_3ff", {24'd0, mem_m[1023]}, 32'hA5);
      chk("mem_byte_400", {24'd0, mem_m[1024]}, 32'h00);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
